// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU; one operation in flight.
// Optional opcode legality check is enabled by defining ALU_ARBITER_OPCHECK_EN.
module alu_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_op,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_op,

    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_s,
    input  logic         alu_zero,

    output logic         rsp0_valid,
    output logic [W-1:0] rsp0_s,
    output logic         rsp0_zero,
    output logic         rsp0_err,
    input  logic         rsp0_ready,

    output logic         rsp1_valid,
    output logic [W-1:0] rsp1_s,
    output logic         rsp1_zero,
    output logic         rsp1_err,
    input  logic         rsp1_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic           owner_q, owner_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   s_q, s_d;
    logic           zero_q, zero_d;
    logic           err_q, err_d;
    logic           grant;
    logic           op_ok;

`ifdef ALU_ARBITER_OPCHECK_EN
    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            3'b010, 3'b110, 3'b000, 3'b001, 3'b111: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    endfunction

    assign op_ok = op_legal(op_q);
`else
    assign op_ok = 1'b1;
`endif

    // With no contender the pointer still nominates the requester that would win a tie.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end else if (req0_valid) begin
            grant = 1'b0;
        end else begin
            grant = ~last_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        s_d        = s_q;
        zero_d     = zero_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = 3'b000;
        rsp0_valid = 1'b0;
        rsp0_s     = '0;
        rsp0_zero  = 1'b0;
        rsp0_err   = 1'b0;
        rsp1_valid = 1'b0;
        rsp1_s     = '0;
        rsp1_zero  = 1'b0;
        rsp1_err   = 1'b0;

        // Outputs are forced quiet while reset is held, whatever state the flops are in.
        if (resetn) begin
            case (state_q)
                IDLE: begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    if ((req0_valid && !grant) || (req1_valid && grant)) begin
                        owner_d = grant;
                        last_d  = grant;
                        a_d     = grant ? req1_a  : req0_a;
                        b_d     = grant ? req1_b  : req0_b;
                        op_d    = grant ? req1_op : req0_op;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    if (op_ok) begin
                        alu_a  = a_q;
                        alu_b  = b_q;
                        alu_op = op_q;
                    end
                    s_d     = op_ok ? alu_s : '0;
                    zero_d  = op_ok ? alu_zero : 1'b1;
                    err_d   = ~op_ok;
                    state_d = RESP;
                end
                RESP: begin
                    if (!owner_q) begin
                        rsp0_valid = 1'b1;
                        rsp0_s     = s_q;
                        rsp0_zero  = zero_q;
                        rsp0_err   = err_q;
                        if (rsp0_ready) state_d = IDLE;
                    end else begin
                        rsp1_valid = 1'b1;
                        rsp1_s     = s_q;
                        rsp1_zero  = zero_q;
                        rsp1_err   = err_q;
                        if (rsp1_ready) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'b000;
            s_q     <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            s_q     <= s_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: W, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: reqK_valid  input  1  requester K (K=0,1) has an operation pending.
REQ-005 SHALL have ports: reqK_ready  output  1  arbiter accepts requester K this cycle.
REQ-006 SHALL have ports: reqK_a, reqK_b  input  W  operands from requester K.
REQ-007 SHALL have ports: reqK_op  input  3  ALU opcode: 010 add, 110 sub, 000 and, 001 or, 111 set-less-than (unsigned).
REQ-008 SHALL have ports: alu_a, alu_b  output  W  and alu_op  output  3  driving the shared ALU.
REQ-009 SHALL have ports: alu_s  input  W  and alu_zero  input  1  results from the shared combinational ALU.
REQ-010 SHALL have ports: rspK_valid  output  1, rspK_s  output  W, rspK_zero  output  1, rspK_err  output  1  response to requester K.
REQ-011 SHALL have ports: rspK_ready  input  1  requester K consumes its response.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-013 In IDLE, SHALL assert reqK_ready for exactly one requester: the granted requester per round-robin; all other reqK_ready SHALL be 0; in EXEC/RESP all reqK_ready SHALL be 0.
REQ-014 Round-robin: when only one reqK_valid is high, that requester SHALL be granted; when both are high, the requester not granted last SHALL win; the last-grant pointer SHALL update only on an accepted transfer (valid & ready).
REQ-015 On acceptance, SHALL register a, b, op and the owner ID, then go IDLE->EXEC.
REQ-016 In EXEC, SHALL drive alu_a/alu_b/alu_op from the registers, capture alu_s/alu_zero at the end of the cycle, and go EXEC->RESP; outside EXEC, alu_a, alu_b and alu_op SHALL be 0.
REQ-017 In RESP, SHALL assert rspK_valid only for the owner, with rspK_s/rspK_zero/rspK_err stable until rspK_ready is high; then go RESP->IDLE.
REQ-018 Latency: accept in cycle N -> ALU driven in N+1 -> rsp_valid high from N+2; one operation outstanding at most; minimum 3 cycles per operation.
REQ-019 A new request SHALL NOT be accepted in the cycle its predecessor's response is consumed; the next acceptance is the following IDLE cycle.
REQ-020 Non-owner rspK_valid SHALL be 0; rspK_ready asserted by a non-owner or outside RESP SHALL be ignored.
REQ-021 reqK_valid deasserting before acceptance SHALL withdraw the request without side effects.

Reset
REQ-022 When resetn is 0 at a rising edge, SHALL enter IDLE, set the last-grant pointer to requester 1 (requester 0 wins first tie), and clear operand, op, result and owner registers.
REQ-023 During and after reset, all reqK_ready, rspK_valid, rspK_s, rspK_zero, rspK_err, alu_a, alu_b and alu_op SHALL be 0.
REQ-024 Reset asserted in EXEC or RESP SHALL abort the operation; no response SHALL be issued for it.

Configuration
REQ-025 Macro ALU_ARBITER_OPCHECK_EN defined: an accepted op outside {010,110,000,001,111} SHALL bypass the ALU (alu_op stays 000, alu_a/alu_b stay 0 in EXEC) and respond with rsp_s=0, rsp_zero=1, rsp_err=1, same latency.
REQ-026 Macro undefined: every op SHALL pass to the ALU unchanged; rspK_err SHALL be tied to 0.

Verification
REQ-027 Reset, then req0 a=5 b=3 op=010 -> req0_ready in cycle 0, alu_a=5/alu_op=010 in cycle 1, rsp0_valid with s=8, zero=0 in cycle 2.
REQ-028 Both requesters valid in the same IDLE cycle after reset (req0 op=110 a=7 b=7, req1 op=001 a=0xF0 b=0x0F) -> req0 served first with s=0, zero=1; then req1 with s=0xFF.
REQ-029 Both requesters held valid for 4 operations -> grants alternate 0,1,0,1 with no starvation.
REQ-030 rsp1_ready held low for 5 cycles with a response pending -> rsp1_valid/rsp1_s stay stable; no reqK_ready is asserted; completion occurs on the first cycle rsp1_ready is high.
REQ-031 resetn low for one cycle during EXEC of req0 op=111 a=1 b=2 -> no rsp0_valid; FSM in IDLE; next tie goes to req0.
REQ-032 With ALU_ARBITER_OPCHECK_EN, op=011 -> rsp_err=1, s=0, zero=1, alu_op=000 throughout; without the macro -> rsp_err=0, s=alu_s.
